// File: rtl/float_pkg.sv
// Shared float helpers for the CNN datapath: field widths, field extraction,
// max-finite magnitude and the accumulator FSM state type.
package float_pkg;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} acc_state_t;

  function automatic int exp_w(input int dw);
    return (dw == 16) ? 5 : (dw == 64) ? 11 : 8;
  endfunction

  function automatic int mant_w(input int dw);
    return dw - 1 - exp_w(dw);
  endfunction

  function automatic logic f_sign(input logic [63:0] v, input int dw);
    return v[dw-1];
  endfunction

  function automatic logic [10:0] f_exp(input logic [63:0] v, input int dw);
    logic [63:0] t;
    t = (v >> mant_w(dw)) & ((64'd1 << exp_w(dw)) - 64'd1);
    return t[10:0];
  endfunction

  function automatic logic [51:0] f_mant(input logic [63:0] v, input int dw);
    logic [63:0] t;
    t = v & ((64'd1 << mant_w(dw)) - 64'd1);
    return t[51:0];
  endfunction

  // Exponent field 0 is zero regardless of the mantissa bits.
  function automatic logic f_is_zero(input logic [63:0] v, input int dw);
    return f_exp(v, dw) == 11'd0;
  endfunction

  // Magnitude (no sign) of the largest finite value: exp all-ones minus 1, mant all-ones.
  function automatic logic [63:0] max_finite(input int dw);
    return ((64'd1 << (dw - 1)) - 64'd1) - (64'd1 << mant_w(dw));
  endfunction

endpackage

// File: rtl/float_acc_if.sv
// Stream interface of float_acc: operand input with last marker, result output.
interface float_acc_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output in_data, in_valid, in_last, out_ready,
                  input  in_ready, out_data, out_valid);
  modport slave  (input  in_data, in_valid, in_last, out_ready,
                  output in_ready, out_data, out_valid);
endinterface

// File: rtl/float_align.sv
// Combinational magnitude compare, swap and right-shift of the smaller operand.
module float_align
  import float_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int EW = exp_w(DATA_WIDTH),
  localparam int MW = mant_w(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  l_sign,
  output logic [EW-1:0]         l_exp,
  output logic [MW:0]           l_man,
  output logic [MW:0]           s_man,
  output logic                  same_sign,
  output logic                  l_zero
);
  localparam logic [EW-1:0] D_MAX = EW'(MW + 1);

  logic                  za, zb, a_big;
  logic [DATA_WIDTH-2:0] ka, kb;
  logic [DATA_WIDTH-1:0] lv, sv;
  logic                  zs;
  logic [EW-1:0]         e_s, d;
  logic [MW:0]           s_full;

  assign za = f_is_zero(64'(a), DATA_WIDTH);
  assign zb = f_is_zero(64'(b), DATA_WIDTH);
  assign ka = za ? '0 : a[DATA_WIDTH-2:0];
  assign kb = zb ? '0 : b[DATA_WIDTH-2:0];
  assign a_big = ka >= kb;

  assign lv     = a_big ? a : b;
  assign sv     = a_big ? b : a;
  assign l_zero = a_big ? za : zb;
  assign zs     = a_big ? zb : za;

  assign l_sign    = f_sign(64'(lv), DATA_WIDTH);
  assign same_sign = l_sign == f_sign(64'(sv), DATA_WIDTH);
  assign l_exp     = EW'(f_exp(64'(lv), DATA_WIDTH));
  assign e_s       = EW'(f_exp(64'(sv), DATA_WIDTH));
  assign l_man     = l_zero ? '0 : {1'b1, MW'(f_mant(64'(lv), DATA_WIDTH))};
  assign s_full    = zs ? '0 : {1'b1, MW'(f_mant(64'(sv), DATA_WIDTH))};

  // Bits shifted out are dropped (truncation, no sticky).
  assign d     = l_exp - e_s;
  assign s_man = (d > D_MAX) ? '0 : (s_full >> d);
endmodule

// File: rtl/float_acc.sv
// Sequential float accumulator: align/add/normalize FSM, one sum per last-terminated vector.
// FLOAT_ACC_SAT_EN: overflow saturates to max finite of L's sign; otherwise flushes to +0.
module float_acc
  import float_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  float_acc_if.slave bus
);
  localparam int EW = exp_w(DATA_WIDTH);
  localparam int MW = mant_w(DATA_WIDTH);

  acc_state_t            state;
  logic [DATA_WIDTH-1:0] acc, x, out_q;
  logic                  last, rdy, vld;

  logic                  a_lsign, a_same, a_lzero;
  logic [EW-1:0]         a_lexp;
  logic [MW:0]           a_lman, a_sman;

  logic                  lsign, same, lzero;
  logic [EW-1:0]         le, re;
  logic [MW:0]           ml, ms, rm;

  logic [MW+1:0]         sum;
  logic [EW-1:0]         e_inc, ne;
  logic [MW:0]           nm;
  logic [DATA_WIDTH-1:0] add_res, norm_res, fin_res, ovf_res;
  logic                  add_norm, norm_done, fin;

  float_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .a(acc), .b(x),
    .l_sign(a_lsign), .l_exp(a_lexp), .l_man(a_lman), .s_man(a_sman),
    .same_sign(a_same), .l_zero(a_lzero)
  );

`ifdef FLOAT_ACC_SAT_EN
  localparam logic [DATA_WIDTH-2:0] MAX_MAG = (DATA_WIDTH-1)'(max_finite(DATA_WIDTH));
  assign ovf_res = {lsign, MAX_MAG};
`else
  assign ovf_res = '0;
`endif

  assign sum   = same ? ({1'b0, ml} + {1'b0, ms}) : ({1'b0, ml} - {1'b0, ms});
  assign e_inc = le + EW'(1);

  always_comb begin
    add_res  = '0;
    add_norm = 1'b0;
    if (lzero || sum == '0) add_res = '0;
    else if (sum[MW+1]) begin
      // Carry: the exponent reaching all-ones is an overflow.
      if (e_inc == '1) add_res = ovf_res;
      else             add_res = {lsign, e_inc, sum[MW:1]};
    end
    else if (sum[MW]) add_res = {lsign, le, sum[MW-1:0]};
    else add_norm = 1'b1;
  end

  assign nm        = rm << 1;
  assign ne        = re - EW'(1);
  assign norm_done = (ne == '0) || nm[MW];
  assign norm_res  = (ne == '0) ? '0 : {lsign, ne, nm[MW-1:0]};

  assign fin     = (state == S_ADD && !add_norm) || (state == S_NORM && norm_done);
  assign fin_res = (state == S_NORM) ? norm_res : add_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      x     <= '0;
      last  <= 1'b0;
      rdy   <= 1'b0;
      vld   <= 1'b0;
      out_q <= '0;
      lsign <= 1'b0;
      same  <= 1'b0;
      lzero <= 1'b0;
      le    <= '0;
      re    <= '0;
      ml    <= '0;
      ms    <= '0;
      rm    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && rdy) begin
            x     <= bus.in_data;
            last  <= bus.in_last;
            rdy   <= 1'b0;
            state <= S_ALIGN;
          end else rdy <= 1'b1;
        end
        S_ALIGN: begin
          lsign <= a_lsign;
          same  <= a_same;
          lzero <= a_lzero;
          le    <= a_lexp;
          ml    <= a_lman;
          ms    <= a_sman;
          state <= S_ADD;
        end
        S_ADD: begin
          if (add_norm) begin
            rm    <= sum[MW:0];
            re    <= le;
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (!norm_done) begin
            rm <= nm;
            re <= ne;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            vld   <= 1'b0;
            acc   <= '0;
            rdy   <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (fin) begin
        acc <= fin_res;
        if (last) begin
          out_q <= fin_res;
          vld   <= 1'b1;
          state <= S_OUT;
        end else begin
          rdy   <= 1'b1;
          state <= S_IDLE;
        end
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out_data  = out_q;
endmodule

// File: tb/tb_float_acc.sv
// Directed self-checking bench for float_acc (DATA_WIDTH=32).
module tb_float_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  float_acc_if #(.DATA_WIDTH(32)) bus ();

  float_acc #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef FLOAT_ACC_SAT_EN
  localparam logic [31:0] OVF_EXP = 32'h7F7FFFFF;
`else
  localparam logic [31:0] OVF_EXP = 32'h00000000;
`endif

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic drive_op(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Rising edges counted from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_data=%h required 0/0/00000000",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (bus.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL idle_ready: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    drive_op(32'h3F800000, 1'b0);
    drive_op(32'h40000000, 1'b1);
    wait_out(lat);
    cmp_cnt++;
    if (bus.out_data !== 32'h40400000) begin
      err_cnt++;
      $display("FAIL basic_sum: got %h required 40400000", bus.out_data);
    end
    cmp_cnt++;
    if (lat !== 3) begin
      err_cnt++;
      $display("FAIL basic_latency: got %0d required 3", lat);
    end
    take_out();
  endtask

  task automatic test_multi();
    int lat;
    for (int i = 0; i < 4; i++) drive_op(32'h3F800000, i == 3);
    wait_out(lat);
    cmp_cnt++;
    if (bus.out_data !== 32'h40800000) begin
      err_cnt++;
      $display("FAIL multi_sum: got %h required 40800000", bus.out_data);
    end
    take_out();
    drive_op(32'h3F800000, 1'b1);
    wait_out(lat);
    cmp_cnt++;
    if (bus.out_data !== 32'h3F800000) begin
      err_cnt++;
      $display("FAIL acc_cleared: got %h required 3F800000", bus.out_data);
    end
    take_out();
  endtask

  task automatic test_cancel();
    int lat;
    drive_op(32'h3FC00000, 1'b0);
    drive_op(32'hBF800000, 1'b1);
    wait_out(lat);
    cmp_cnt++;
    if (bus.out_data !== 32'h3F000000) begin
      err_cnt++;
      $display("FAIL norm_sum: got %h required 3F000000", bus.out_data);
    end
    cmp_cnt++;
    if (lat !== 4) begin
      err_cnt++;
      $display("FAIL norm_latency: got %0d required 4", lat);
    end
    take_out();
    drive_op(32'h3F800000, 1'b0);
    drive_op(32'hBF800000, 1'b1);
    wait_out(lat);
    cmp_cnt++;
    if (bus.out_data !== 32'h00000000) begin
      err_cnt++;
      $display("FAIL exact_cancel: got %h required 00000000", bus.out_data);
    end
    take_out();
  endtask

  task automatic test_align();
    int lat;
    drive_op(32'h4B800000, 1'b0);
    drive_op(32'h3F800000, 1'b1);
    wait_out(lat);
    cmp_cnt++;
    if (bus.out_data !== 32'h4B800000) begin
      err_cnt++;
      $display("FAIL shift_out: got %h required 4B800000", bus.out_data);
    end
    take_out();
    drive_op(32'h00000000, 1'b0);
    drive_op(32'hC0400000, 1'b1);
    wait_out(lat);
    cmp_cnt++;
    if (bus.out_data !== 32'hC0400000) begin
      err_cnt++;
      $display("FAIL zero_operand: got %h required C0400000", bus.out_data);
    end
    take_out();
  endtask

  task automatic test_overflow();
    int lat;
    drive_op(32'h7F000000, 1'b0);
    drive_op(32'h7F000000, 1'b1);
    wait_out(lat);
    cmp_cnt++;
    if (bus.out_data !== OVF_EXP) begin
      err_cnt++;
      $display("FAIL overflow: got %h required %h", bus.out_data, OVF_EXP);
    end
    take_out();
  endtask

  task automatic test_hold();
    int lat;
    drive_op(32'h3F800000, 1'b0);
    drive_op(32'h40000000, 1'b1);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h40400000 || bus.in_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL hold_%0d: out_valid=%b out_data=%h in_ready=%b required 1/40400000/0",
                 i, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    take_out();
    cmp_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_rst_mid();
    int lat;
    drive_op(32'h3FC00000, 1'b0);
    drive_op(32'hBF800000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp_cnt++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b out_data=%h required 0/0/00000000",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_op(32'h3F800000, 1'b0);
    drive_op(32'h40000000, 1'b1);
    wait_out(lat);
    cmp_cnt++;
    if (bus.out_data !== 32'h40400000) begin
      err_cnt++;
      $display("FAIL after_reset_sum: got %h required 40400000", bus.out_data);
    end
    take_out();
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_multi();
    test_cancel();
    test_align();
    test_overflow();
    test_hold();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
